// File: rtl/apb_mem_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : apb_mem_subsystem
// Description : APB master FSM driven by a simple request port, bridged to a
//               word-addressed register memory slave with programmable wait
//               states and PSLVERR on out-of-range accesses. Back-to-back
//               transfers are supported by capturing a new request on the
//               completion edge.
//               Optional feature macro: APB_PSTRB_EN (adds WRITE_STRB byte
//               lane enables for writes).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module apb_mem_subsystem #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PTRANSFER,
    input  logic [ADDR_W-1:0]   ADDRESS,
    input  logic [DATA_W-1:0]   WRITE_DATA,
    input  logic                WRITE_EN,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] WRITE_STRB,
`endif
    output logic [DATA_W-1:0]   READ_DATA,
    output logic                XFER_DONE,
    output logic                XFER_ERR,
    output logic                BUSY,
    output logic                PSEL,
    output logic                PENABLE
);

    localparam int c_LANES = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_LANES);
    localparam int c_IDX_W = $clog2(DEPTH);
    // First byte address beyond the memory; one extra bit so it always fits.
    localparam logic [ADDR_W:0] c_MEM_BYTES = (ADDR_W + 1)'(DEPTH * c_LANES);
    localparam logic [7:0]      c_WAIT_LOAD = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_write;
    logic [c_LANES-1:0]   r_strb;
    logic [7:0]           r_wait_cnt;
    logic [DATA_W-1:0]    r_mem [DEPTH];

    logic [c_LANES-1:0]   w_strb_in;
    logic [DATA_W-1:0]    w_wmask;
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_pready;
    logic                 w_pslverr;
    logic                 w_complete;
    logic                 w_capture;

`ifdef APB_PSTRB_EN
    assign w_strb_in = WRITE_STRB;
`else
    assign w_strb_in = '1;
`endif

    // Slave side: ready once the wait counter has drained, error when the
    // captured address lies beyond the memory.
    assign w_pready   = (r_wait_cnt == 8'd0);
    assign w_pslverr  = ({1'b0, r_addr} >= c_MEM_BYTES);
    assign w_idx      = r_addr[c_OFF_W +: c_IDX_W];
    assign w_complete = (r_state == ST_ACCESS) && w_pready;
    assign w_capture  = PTRANSFER && ((r_state == ST_IDLE) || w_complete);

    // Expand the captured byte strobes into a bit mask.
    for (genvar i = 0; i < c_LANES; i++) begin : g_lane_mask
        assign w_wmask[8*i +: 8] = {8{r_strb[i]}};
    end

    // Master state register.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and APB control outputs.
    always_comb begin
        w_state_nxt = r_state;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        BUSY        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PTRANSFER) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL        = 1'b1;
                BUSY        = 1'b1;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                BUSY    = 1'b1;
                if (w_pready) begin
                    // A request present on the completion edge skips IDLE.
                    w_state_nxt = PTRANSFER ? ST_SETUP : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture; requests arriving mid-transfer are dropped.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_strb  <= '0;
        end else if (w_capture) begin
            r_addr  <= ADDRESS;
            r_wdata <= WRITE_DATA;
            r_write <= WRITE_EN;
            r_strb  <= w_strb_in;
        end
    end

    // Slave wait-state counter: loaded entering ACCESS, drains while in it.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= c_WAIT_LOAD;
        end else if ((r_state == ST_ACCESS) && (r_wait_cnt != 8'd0)) begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
        end
    end

    // Memory array: cleared on reset, masked write on an in-range completion.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_complete && r_write && !w_pslverr) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (r_wdata & w_wmask);
        end
    end

    // Completion results: read data, done pulse and error flag.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            READ_DATA <= '0;
            XFER_DONE <= 1'b0;
            XFER_ERR  <= 1'b0;
        end else begin
            XFER_DONE <= w_complete;
            XFER_ERR  <= w_complete && w_pslverr;
            if (w_complete && !r_write) begin
                READ_DATA <= w_pslverr ? '0 : r_mem[w_idx];
            end
        end
    end

endmodule
`default_nettype wire
